ysyx_24070014_sram_responder: RTL

Memory-side responder for the core's load/store and fetch path. It replaces the direct combinational DPI-C physical-memory calls with a valid/ready request/response slave. The block holds a word-addressed SRAM array and answers one outstanding request at a time after a programmable latency. It sits between the core's memory stage (or IFU) and the backing store, so timing-dependent core handshaking can be exercised.

---
 rtl/ysyx_24070014_sram_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24070014_sram_responder.sv
// Valid/ready SRAM responder: one outstanding request, fixed wait before the access.
// Optional YSYX_24070014_SRAM_RAND_DELAY_EN adds 0-7 LFSR-chosen extra wait cycles per request.
module ysyx_24070014_sram_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [4:0]              cnt_r;
    logic [4:0]              cnt_nxt_s;
    logic [4:0]              load_cnt_s;
    logic                    accept_s;
    logic                    enter_resp_s;
    logic                    resp_done_s;
    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic                    resp_err_r;
    logic [DATA_WIDTH-1:0]   resp_rdata_r;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    wen_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [3:0]              wmask_r;

    logic [ADDR_WIDTH-1:0]   offset_s;
    logic [ADDR_WIDTH-1:0]   widx_full_s;
    logic [DEPTH_LOG2-1:0]   index_s;
    logic                    err_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            mask
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

`ifdef YSYX_24070014_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_r;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign load_cnt_s = 5'(LATENCY) + {2'b00, lfsr_r[2:0]};
`else
    assign load_cnt_s = 5'(LATENCY);
`endif

    // Address decode on the latched request; the below-base test uses the raw address.
    always_comb begin
        offset_s    = addr_r - BASE_ADDR;
        widx_full_s = offset_s >> 2;
        index_s     = widx_full_s[DEPTH_LOG2-1:0];
        err_s       = (addr_r[1:0] != 2'b00) || (addr_r < BASE_ADDR) ||
                      (widx_full_s >= ADDR_WIDTH'(DEPTH));
        rd_word_s   = mem_r[index_s];
    end

    // Next-state logic; the counter holds wait cycles still to go, so RESP lands LATENCY+1 edges after accept.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        resp_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = load_cnt_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 5'd0) begin
                    enter_resp_s = 1'b1;
                    state_nxt_s  = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 5'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_done_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 5'd0;
            end
        endcase
    end

    // State, counter and request-ready registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
        end
    end

    // Request capture at the accept handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wen_r   <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
            wmask_r <= 4'b0000;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wen_r   <= req_wen;
            wdata_r <= req_wdata;
            wmask_r <= req_wmask;
        end
    end

    // Array write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (enter_resp_s && wen_r && !err_s) begin
            mem_r[index_s] <= merge_bytes(mem_r[index_s], wdata_r, wmask_r);
        end
    end

    // Response registers, held until the requester takes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (enter_resp_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_s;
            resp_rdata_r <= (err_s || wen_r) ? {DATA_WIDTH{1'b0}} : rd_word_s;
        end else if (resp_done_s) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule
